// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
// Holds the arbiter FSM state encoding and small helpers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arbState_t;

  // Memory request is asserted in every non-idle state.
  function automatic logic isBusy(input arbState_t s);
    return (s == DATA) || (s == FETCH);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and M-stage access.
// Ports: clk/reset, fetch (IReqF,PCF,InstrF), data (DReqM,MemWriteM,
// ALUOutM,WriteDataM,ReadDataM), MemStallF, memory req/ack interface.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IReqF,
  input  logic [WIDTH-1:0] PCF,
  input  logic             DReqM,
  input  logic             MemWriteM,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] InstrF,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             MemStallF,
  output logic             MemReq,
  output logic             MemWe,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWData,
  input  logic             MemAck,
  input  logic [WIDTH-1:0] MemRData
);

  arbState_t state;
  arbState_t stateNext;

  logic iDone;
  logic dDone;
  logic iPend;
  logic dPend;
  logic loadD;
  logic loadI;
  logic dAck;
  logic iAck;

  assign iPend = IReqF & ~iDone;
  assign dPend = DReqM & ~dDone;

  assign MemStallF = iPend | dPend;

  // Data access is served before fetch within one advance window.
  always_comb begin
    stateNext = state;
    loadD     = 1'b0;
    loadI     = 1'b0;
    dAck      = 1'b0;
    iAck      = 1'b0;
    unique case (state)
      IDLE: begin
        if (dPend) begin
          stateNext = DATA;
          loadD     = 1'b1;
        end else if (iPend) begin
          stateNext = FETCH;
          loadI     = 1'b1;
        end
      end
      DATA: begin
        if (MemAck) begin
          dAck = 1'b1;
          if (iPend) begin
            stateNext = FETCH;
            loadI     = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      FETCH: begin
        if (MemAck) begin
          iAck      = 1'b1;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      iDone     <= 1'b0;
      dDone     <= 1'b0;
      InstrF    <= '0;
      ReadDataM <= '0;
      MemReq    <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
    end else begin
      state  <= stateNext;
      MemReq <= isBusy(stateNext);

      // Request fields are frozen from entry until the ack cycle.
      if (loadD) begin
        MemAddr  <= ALUOutM;
        MemWe    <= MemWriteM;
        MemWData <= WriteDataM;
      end
      if (loadI) begin
        MemAddr <= PCF;
        MemWe   <= 1'b0;
      end

      // Advance clears flags; a completing access sets its own flag
      // even if its requester has already gone away.
      if (!MemStallF) begin
        iDone <= 1'b0;
        dDone <= 1'b0;
      end
      if (dAck) begin
        dDone <= 1'b1;
        if (!MemWe) begin
          ReadDataM <= MemRData;
        end
      end
      if (iAck) begin
        iDone  <= 1'b1;
        InstrF <= MemRData;
      end
    end
  end

endmodule
